// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared op encodings, FSM state type and default iteration count
// for the iterative multiply/divide unit.
package muldiv_pkg;

   localparam int unsigned ITER_DEFAULT = 32;

   localparam logic [1:0] OP_MULT  = 2'b00;
   localparam logic [1:0] OP_MULTU = 2'b01;
   localparam logic [1:0] OP_DIV   = 2'b10;
   localparam logic [1:0] OP_DIVU  = 2'b11;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      CALC = 2'b01,
      FIX  = 2'b10,
      DONE = 2'b11
   } state_e;

endpackage

// File: rtl/muldiv_core.sv
// muldiv_core: one radix-2 step of the shared 64-bit accumulator.
//   multiply: {hi,lo} holds {partial product, remaining multiplier bits}.
//   divide:   {hi,lo} holds {partial remainder, dividend/quotient bits}.
module muldiv_core (
   input  logic        is_div,
   input  logic [63:0] acc_i,
   input  logic [31:0] opnd_i,
   output logic [63:0] acc_o
);

   logic [32:0] sum;
   logic [31:0] rem_sub;

   // Single iteration: shift-add for multiply, restoring shift-subtract for divide
   always_comb begin
      sum     = {1'b0, acc_i[63:32]} + (acc_i[0] ? {1'b0, opnd_i} : 33'd0);
      rem_sub = acc_i[62:31] - opnd_i;
      if (is_div) begin
         // acc_i[63:31] is the remainder after the left shift (33 bits wide)
         if (acc_i[63:31] >= {1'b0, opnd_i}) begin
            acc_o = {rem_sub, acc_i[30:0], 1'b1};
         end else begin
            acc_o = {acc_i[62:0], 1'b0};
         end
      end else begin
         acc_o = {sum, acc_i[31:1]};
      end
   end

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative 32-bit MULT/MULTU/DIV/DIVU with HI/LO registers and
// MTHI/MTLO direct writes. Define MULDIV_DIV_EN to build the divide path;
// without it DIV/DIVU only produce a Done pulse and leave HI/LO unchanged.
module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int unsigned ITER = ITER_DEFAULT
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        Start,
   input  logic [1:0]  Op,
   input  logic [31:0] A,
   input  logic [31:0] B,
   input  logic        HiWre,
   input  logic        LoWre,
   output logic        Busy,
   output logic        Done,
   output logic        DivByZero,
   output logic [31:0] HI,
   output logic [31:0] LO
);

   localparam int unsigned CW = $clog2(ITER);

   state_e        state_q, state_d;
   logic [63:0]   acc_q, acc_d;
   logic [31:0]   opnd_q, opnd_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          a_neg_q, a_neg_d;
   logic          b_neg_q, b_neg_d;
   logic [31:0]   hi_q, hi_d;
   logic [31:0]   lo_q, lo_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;

   logic          signed_op, a_neg_in, b_neg_in;
   logic [31:0]   abs_a, abs_b;
   logic [63:0]   acc_step, prod_fix;
   logic          is_div;

`ifdef MULDIV_DIV_EN
   logic          div_q, div_d;
   logic          bz_q, bz_d;
   logic          dz_q, dz_d;
   logic [31:0]   quot_fix, rem_fix;

   assign is_div = div_q;
   // A zero divisor leaves rem = |A| and quot = all ones after the loop, so the
   // normal remainder sign rule restores the original dividend; only the
   // quotient negation has to be suppressed.
   assign quot_fix  = ((a_neg_q ^ b_neg_q) && !bz_q) ? (32'd0 - acc_q[31:0]) : acc_q[31:0];
   assign rem_fix   = a_neg_q ? (32'd0 - acc_q[63:32]) : acc_q[63:32];
   assign DivByZero = dz_q;
`else
   assign is_div    = 1'b0;
   assign DivByZero = 1'b0;
`endif

   assign signed_op = (Op == OP_MULT) || (Op == OP_DIV);
   assign a_neg_in  = signed_op & A[31];
   assign b_neg_in  = signed_op & B[31];
   assign abs_a     = a_neg_in ? (32'd0 - A) : A;
   assign abs_b     = b_neg_in ? (32'd0 - B) : B;
   assign prod_fix  = (a_neg_q ^ b_neg_q) ? (64'd0 - acc_q) : acc_q;

   muldiv_core u_core (
      .is_div (is_div),
      .acc_i  (acc_q),
      .opnd_i (opnd_q),
      .acc_o  (acc_step)
   );

   // Next-state, datapath and HI/LO update
   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      opnd_d  = opnd_q;
      cnt_d   = cnt_q;
      a_neg_d = a_neg_q;
      b_neg_d = b_neg_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
`ifdef MULDIV_DIV_EN
      div_d   = div_q;
      bz_d    = bz_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (Start) begin
               a_neg_d = a_neg_in;
               b_neg_d = b_neg_in;
               cnt_d   = '0;
               state_d = CALC;
               if (Op[1]) begin
`ifdef MULDIV_DIV_EN
                  div_d  = 1'b1;
                  bz_d   = (B == 32'd0);
                  opnd_d = abs_b;
                  acc_d  = {32'd0, abs_a};
`else
                  state_d = DONE;
`endif
               end else begin
`ifdef MULDIV_DIV_EN
                  div_d  = 1'b0;
                  bz_d   = 1'b0;
`endif
                  opnd_d = abs_a;
                  acc_d  = {32'd0, abs_b};
               end
            end else begin
               if (HiWre) hi_d = A;
               if (LoWre) lo_d = A;
            end
         end
         CALC: begin
            acc_d = acc_step;
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(ITER - 1)) state_d = FIX;
         end
         FIX: begin
`ifdef MULDIV_DIV_EN
            if (div_q) begin
               hi_d = rem_fix;
               lo_d = quot_fix;
            end else begin
               hi_d = prod_fix[63:32];
               lo_d = prod_fix[31:0];
            end
`else
            hi_d = prod_fix[63:32];
            lo_d = prod_fix[31:0];
`endif
            state_d = DONE;
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase

      busy_d = (state_d != IDLE);
      done_d = (state_d == DONE);
`ifdef MULDIV_DIV_EN
      dz_d   = (state_d == DONE) && div_d && bz_d;
`endif
   end

   // State registers with synchronous active-low reset
   always_ff @(posedge CLK) begin
      if (!RST) begin
         state_q <= IDLE;
         acc_q   <= '0;
         opnd_q  <= '0;
         cnt_q   <= '0;
         a_neg_q <= 1'b0;
         b_neg_q <= 1'b0;
         hi_q    <= '0;
         lo_q    <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
`ifdef MULDIV_DIV_EN
         div_q   <= 1'b0;
         bz_q    <= 1'b0;
         dz_q    <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         opnd_q  <= opnd_d;
         cnt_q   <= cnt_d;
         a_neg_q <= a_neg_d;
         b_neg_q <= b_neg_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
`ifdef MULDIV_DIV_EN
         div_q   <= div_d;
         bz_q    <= bz_d;
         dz_q    <= dz_d;
`endif
      end
   end

   assign Busy = busy_q;
   assign Done = done_q;
   assign HI   = hi_q;
   assign LO   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed vectors for muldiv_unit. Expected {HI,LO,DivByZero}
// is queued when an operation is issued; a monitor pops on every Done pulse.
// Expectations follow the build: with MULDIV_DIV_EN undefined, DIV/DIVU keep
// HI/LO unchanged and finish one cycle after Start.
module tb_muldiv_unit;
   import muldiv_pkg::*;

   logic        CLK = 1'b0;
   logic        RST = 1'b0;
   logic        Start = 1'b0;
   logic [1:0]  Op = 2'b00;
   logic [31:0] A = '0;
   logic [31:0] B = '0;
   logic        HiWre = 1'b0;
   logic        LoWre = 1'b0;
   logic        Busy, Done, DivByZero;
   logic [31:0] HI, LO;

   int          n_cmp = 0;
   int          n_err = 0;
   logic [64:0] exp_q[$];
   logic [64:0] mon_e;
   logic [31:0] m_hi = '0;
   logic [31:0] m_lo = '0;
   logic [31:0] prev_hi;

   muldiv_unit #(.ITER(32)) dut (
      .CLK(CLK), .RST(RST), .Start(Start), .Op(Op), .A(A), .B(B),
      .HiWre(HiWre), .LoWre(LoWre), .Busy(Busy), .Done(Done),
      .DivByZero(DivByZero), .HI(HI), .LO(LO)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: compare every Done pulse against the oldest queued expectation
   always @(negedge CLK) begin
      if (RST && Done) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL done_unexpected: got HI=%h LO=%h DZ=%b with nothing queued", HI, LO, DivByZero);
         end else begin
            mon_e = exp_q.pop_front();
            check("result_hi", {32'd0, HI}, {32'd0, mon_e[64:33]});
            check("result_lo", {32'd0, LO}, {32'd0, mon_e[32:1]});
            check("result_dz", {63'd0, DivByZero}, {63'd0, mon_e[0]});
         end
      end
      if (RST && DivByZero && !Done) begin
         n_cmp++;
         n_err++;
         $display("FAIL dz_without_done: got DivByZero=1 expected 0");
      end
   end

   task automatic wait_idle();
      for (int i = 0; i < 100; i++) begin
         @(negedge CLK);
         if (!Busy) break;
      end
      check("idle_timeout", {63'd0, Busy}, 64'd0);
   endtask

   // Issue one operation, count Busy/Done cycles, optional simultaneous HiWre
   task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] eh, input logic [31:0] el, input logic edz,
                         input logic hw);
      int busy_cyc;
      int done_cyc;
      int exp_busy;
      logic [31:0] hold_hi;
      exp_busy = 34;
`ifndef MULDIV_DIV_EN
      if (op[1]) begin
         eh = m_hi;
         el = m_lo;
         edz = 1'b0;
         exp_busy = 1;
      end
`endif
      hold_hi = m_hi;
      exp_q.push_back({eh, el, edz});
      m_hi = eh;
      m_lo = el;
      @(negedge CLK);
      Op = op; A = a; B = b; Start = 1'b1; HiWre = hw;
      @(posedge CLK);
      #1 Start = 1'b0; HiWre = 1'b0;
      busy_cyc = 0;
      done_cyc = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge CLK);
         if (i == 0 && hw) check("start_beats_mthi", {32'd0, HI}, {32'd0, hold_hi});
         if (Busy) busy_cyc++;
         if (Done) done_cyc++;
         if (!Busy) break;
      end
      check("busy_cycles", 64'(busy_cyc), 64'(exp_busy));
      check("done_cycles", 64'(done_cyc), 64'd1);
   endtask

   initial begin
      RST = 1'b0;
      repeat (2) @(posedge CLK);
      @(negedge CLK);
      check("reset_state", {HI, LO}, 64'd0);
      check("reset_flags", {61'd0, Busy, Done, DivByZero}, 64'd0);
      RST = 1'b1;

      run_op(OP_MULT,  32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0, 1'b0);
      run_op(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 1'b0);
      run_op(OP_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 1'b0);
      run_op(OP_DIVU,  32'd7,        32'd2,        32'd1,        32'd3,        1'b0, 1'b0);
      run_op(OP_DIVU,  32'd7,        32'd0,        32'd7,        32'hFFFFFFFF, 1'b1, 1'b0);
      run_op(OP_DIV,   32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF, 1'b1, 1'b0);
      run_op(OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000, 1'b0, 1'b0);
      run_op(OP_DIV,   32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 1'b0, 1'b0);

      // Start and MTHI while busy are both ignored; HI holds until FIX
      prev_hi = m_hi;
      exp_q.push_back({32'd0, 32'd42, 1'b0});
      m_hi = 32'd0;
      m_lo = 32'd42;
      @(negedge CLK);
      Op = OP_MULT; A = 32'd6; B = 32'd7; Start = 1'b1;
      @(posedge CLK);
      #1 Start = 1'b0;
      repeat (4) @(negedge CLK);
      Op = OP_DIV; A = 32'h1234; Start = 1'b1; HiWre = 1'b1;
      @(posedge CLK);
      #1 Start = 1'b0; HiWre = 1'b0;
      @(negedge CLK);
      check("busy_ignores_mthi", {32'd0, HI}, {32'd0, prev_hi});
      wait_idle();

      // MTHI in IDLE: zero latency, LO untouched
      @(negedge CLK);
      A = 32'h1234; HiWre = 1'b1;
      @(negedge CLK);
      HiWre = 1'b0;
      m_hi = 32'h1234;
      check("mthi_idle", {HI, LO}, {m_hi, m_lo});

      // MTHI and MTLO together: both written from A
      A = 32'hCAFE; HiWre = 1'b1; LoWre = 1'b1;
      @(negedge CLK);
      HiWre = 1'b0; LoWre = 1'b0;
      m_hi = 32'hCAFE;
      m_lo = 32'hCAFE;
      check("mthi_mtlo_both", {HI, LO}, {m_hi, m_lo});

      // Start together with MTHI: Start wins
      run_op(OP_MULTU, 32'd2, 32'd3, 32'd0, 32'd6, 1'b0, 1'b1);

      // Reset in the middle of a DIV aborts and clears HI/LO
`ifndef MULDIV_DIV_EN
      exp_q.push_back({m_hi, m_lo, 1'b0});
`endif
      @(negedge CLK);
      Op = OP_DIV; A = 32'd100; B = 32'd3; Start = 1'b1;
      @(posedge CLK);
      #1 Start = 1'b0;
      repeat (9) @(negedge CLK);
      RST = 1'b0;
      @(negedge CLK);
      check("midop_reset_hilo", {HI, LO}, 64'd0);
      check("midop_reset_flags", {61'd0, Busy, Done, DivByZero}, 64'd0);
      RST = 1'b1;
      m_hi = '0;
      m_lo = '0;

      run_op(OP_MULT, 32'h80000000, 32'd2, 32'hFFFFFFFF, 32'h00000000, 1'b0, 1'b0);

      repeat (3) @(negedge CLK);
      check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
